// File: rtl/multicycle_main_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath controls.
// 3-5 cycles per instruction; stalls in FETCH/MEMRD/MEMWR until mem_ready; unsupported opcodes trap until reset.
module multicycle_main_control #(
  parameter logic [5:0] OPC_RTYPE = 6'b000000,
  parameter logic [5:0] OPC_LW    = 6'b100011,
  parameter logic [5:0] OPC_SW    = 6'b101011,
  parameter logic [5:0] OPC_BEQ   = 6'b000100,
  parameter logic [5:0] OPC_ADDI  = 6'b001000,
  parameter logic [5:0] OPC_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  state_t state;
  logic   pc_write;
  logic   pc_write_cond;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RESET;
    end else begin
      case (state)
        S_RESET:  state <= S_FETCH;
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OPC_LW, OPC_SW: state <= S_MEMADR;
            OPC_RTYPE:      state <= S_EXEC;
            OPC_BEQ:        state <= S_BRANCH;
            OPC_ADDI:       state <= S_ADDIEX;
            OPC_J:          state <= S_JUMP;
            default:        state <= S_TRAP;
          endcase
        end
        // IR still holds the LW/SW opcode, so it picks the access direction
        S_MEMADR: state <= (opcode == OPC_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:  state <= S_FETCH;
        S_MEMWR:  if (mem_ready) state <= S_FETCH;
        S_EXEC:   state <= S_ALUWB;
        S_ALUWB:  state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        S_ADDIEX: state <= S_ADDIWB;
        S_ADDIWB: state <= S_FETCH;
        S_JUMP:   state <= S_FETCH;
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_TRAP;
      endcase
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        i_or_d     = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_TRAP: illegal_op = 1'b1;
      default: ;
    endcase
  end

  assign pc_en     = pc_write | (pc_write_cond & zero);
  assign state_dbg = state;

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback over several clocks per instruction.
- Drives every datapath mux and enable, and supplies the 2-bit alu_op consumed by the existing ALU function decoder.
- Stalls on a single-port memory ready handshake; traps on unsupported opcodes.

Parameters:
- OPC_RTYPE, 6'b000000, R-type opcode
- OPC_LW, 6'b100011, load word
- OPC_SW, 6'b101011, store word
- OPC_BEQ, 6'b000100, branch if equal
- OPC_ADDI, 6'b001000, add immediate
- OPC_J, 6'b000010, jump

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  6  instr[31:26] from the instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- pc_en  output  1  PC load enable = pc_write | (pc_write_cond & zero)
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  writeback data select: 1 = MDR, 0 = ALUOut
- reg_dst  output  1  destination register select: 1 = rd, 0 = rt
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = register A
- alu_src_b  output  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op  output  2  00 = add, 01 = sub, 10 = decode funct
- pc_source  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  output  1  one-cycle pulse when an instruction retires
- illegal_op  output  1  high while in TRAP
- state_dbg  output  4  current state encoding

Behaviour:
- 4-bit state register; all outputs are combinational from state, plus mem_ready in FETCH, MEMRD and MEMWR.
- Unlisted outputs are 0 in every state.
- Encodings: RESET=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12, TRAP=13.
- Reset: reset high at a clock edge forces state to RESET, from any state, including mid-access. Reset has priority over all transitions.
- RESET: every output 0. Next state is FETCH unconditionally.
- FETCH:
  - mem_read=1, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=mem_ready; pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; moves to DECODE when mem_ready=1.
- DECODE: alu_src_b=11, alu_op=00 (branch target computed into ALUOut). Next state by opcode:
  - LW or SW -> MEMADR
  - RTYPE -> EXEC
  - BEQ -> BRANCH
  - ADDI -> ADDIEX
  - J -> JUMP
  - anything else -> TRAP
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEMRD for LW, MEMWR for SW.
- MEMRD: i_or_d=1, mem_read=1. Holds while mem_ready=0; moves to MEMWB when mem_ready=1.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state FETCH.
- MEMWR: i_or_d=1, mem_write=1. Holds while mem_ready=0. When mem_ready=1: instr_done=1 and next state FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1.
  - pc_en=zero.
  - Next state FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next state FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next state FETCH.
- TRAP: illegal_op=1, all other outputs 0. Stays in TRAP until reset.
- Exclusivity: mem_read and mem_write are never high together.
- Cycle counts with mem_ready=1 throughout:
  - LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3.
  - Each cycle spent with mem_ready=0 in FETCH, MEMRD or MEMWR adds one.
- Unreachable encodings 14 and 15: next state TRAP.

Test Plan:
- Reset held 2 cycles then released -> state_dbg=0 with all outputs 0; next cycle state_dbg=1 with mem_read=1, pc_en=0 while mem_ready=0.
- R-type, mem_ready=1 -> states 1,2,7,8,1. alu_op=10 in EXEC. reg_write=1, reg_dst=1 and instr_done=1 in ALUWB.
- LW with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles with i_or_d=1 and mem_read=1; then MEMWB with reg_write=1, mem_to_reg=1; total 8 cycles.
- BEQ with zero=1 versus zero=0 -> BRANCH shows alu_op=01, pc_source=01; pc_en=1 for zero=1 and pc_en=0 for zero=0; both return to FETCH.
- Opcode 6'b111111 -> DECODE then TRAP; illegal_op=1 for 10+ cycles; reset returns state to 0.
- Reset asserted during MEMWR with mem_ready=0 -> next state RESET; mem_write=0; no instr_done pulse.
